instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Next-generation instruction ROM: a parametrised, loadable instruction memory with its own PC register, sequencing FSM and registered instruction output.
- Sits between the program loader/testbench and the instruction decode controller.
- Replaces combinational address-in/instruction-out lookup with sequential fetch, supporting stall, branch redirect and end-of-program halt.

Parameters:
- NUMBER_OF_PC_REGISTERS, 256, instruction memory depth; PC_WIDTH = $clog2 of this.
- OPERATION_TYPE_WIDTH, 2, operation-type field width.
- OPCODE_WIDTH, 4, opcode field width.
- NUMBER_OF_REGISTERS, 32, register file size; ADDR_WIDTH = $clog2 of this.
- WORD_SIZE, 32, immediate/data word width.
- INSTR_WIDTH, derived: OPERATION_TYPE_WIDTH + OPCODE_WIDTH + 3*ADDR_WIDTH + PC_WIDTH + WORD_SIZE (61 at defaults).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  loader write enable.
- prog_addr  in  PC_WIDTH  loader write address.
- prog_data  in  INSTR_WIDTH  loader write data.
- run  in  1  level; 1 = fetch, 0 = return to IDLE.
- stall  in  1  decode back-pressure; freezes the fetch.
- branch_en  in  1  redirect request.
- branch_target  in  PC_WIDTH  redirect address.
- instr_out  out  INSTR_WIDTH  registered fetched instruction.
- instr_valid  out  1  instr_out is a live instruction.
- pc_out  out  PC_WIDTH  address of the instruction in instr_out.
- halted  out  1  FSM is in HALT.

Behaviour:
- Reset (rst=1 at edge), any state:
  - state=IDLE; PC=0.
  - instr_out=0, instr_valid=0, pc_out=0, halted=0.
  - Memory contents are not cleared.
  - rst has priority over every other input.
- States: IDLE, FETCH, HALT.
- IDLE:
  - prog_we=1 writes Imem[prog_addr] <= prog_data.
  - instr_valid=0.
  - run=1 moves to FETCH next cycle with PC=0.
- prog_we in FETCH or HALT is ignored; memory is unchanged.
- FETCH, each cycle (priority order):
  1. run=0: go to IDLE, PC=0, instr_valid=0.
  2. branch_en=1: PC <= branch_target; instr_valid <= 0 (one bubble). Branch overrides stall.
  3. stall=1: PC, instr_out, pc_out and instr_valid all hold.
  4. Otherwise: instr_out <= Imem[PC], pc_out <= PC, instr_valid <= 1, PC <= PC+1.
- Latency:
  - First valid instruction appears 2 cycles after run rises in IDLE (one cycle to enter FETCH, one cycle to read).
  - After a branch, the target instruction is valid 2 cycles after branch_en.
- End of program: a normal fetch at PC = NUMBER_OF_PC_REGISTERS-1 presents that instruction (valid=1), then the FSM goes to HALT (see Optional Feature).
- HALT:
  - halted=1; instr_valid=0 from the first HALT cycle.
  - PC holds; branch_en and stall are ignored.
  - run=0 returns to IDLE with PC=0.
- Arithmetic: PC+1 is computed in PC_WIDTH bits. A branch_target out of range cannot occur, because the depth is a power of two.

Optional Feature:
- Macro: IFU_PC_WRAP_EN.
- Defined: the fetch at the last address wraps PC to 0 and FETCH continues; HALT is unreachable and halted is tied 0.
- Undefined: end-of-program HALT behaviour as specified above.

Decomposition:
- Shared package/defines (existing defines header):
  - NUMBER_OF_PC_REGISTERS, OPERATION_TYPE_WIDTH, OPCODE_WIDTH, NUMBER_OF_REGISTERS, WORD_SIZE.
  - Derived INSTR_WIDTH.
  - FSM state encoding: IDLE=2'd0, FETCH=2'd1, HALT=2'd2.
- One sub-module, instr_mem_sp:
  - Synchronous-write, synchronous-read single-port RAM.
  - Depth NUMBER_OF_PC_REGISTERS, width INSTR_WIDTH.
  - Read enable driven by the FSM.
- FSM and PC logic stay in the top module.

Test Plan:
- Load/run: rst; in IDLE write Imem[0..3] = 'h10,'h11,'h12,'h13; raise run -> instr_out = 'h10 valid 2 cycles later, then 'h11, 'h12, 'h13 on consecutive cycles with pc_out = 0,1,2,3.
- Stall: during a run, assert stall for 3 cycles while instr_out='h11 -> instr_out, pc_out, valid held for 3 cycles; 'h12 appears on the first cycle after stall drops.
- Branch: branch_en=1, branch_target=8 with Imem[8]='hAA -> next cycle instr_valid=0; following cycle instr_out='hAA, pc_out=8. Repeat with stall=1 in the same cycle -> identical result (branch wins).
- End of program, macro undefined: branch to 254 -> instructions from 254 and 255 valid; halted=1 next cycle, valid=0. Drop run -> IDLE, halted=0. Macro defined -> fetch continues at pc_out=0.
- Write protect: prog_we=1 to address 5 during FETCH -> Imem[5] unchanged on a later read.
- Reset mid-run: rst=1 for one cycle while valid=1, pc_out=7 -> next cycle valid=0, pc_out=0, state IDLE, memory contents preserved on rerun.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared widths, derived instruction width and FSM encoding for the fetch unit
package instr_fetch_unit_pkg;

  localparam int NUMBER_OF_PC_REGISTERS = 256;
  localparam int OPERATION_TYPE_WIDTH   = 2;
  localparam int OPCODE_WIDTH           = 4;
  localparam int NUMBER_OF_REGISTERS    = 32;
  localparam int WORD_SIZE              = 32;

  localparam int PC_WIDTH    = $clog2(NUMBER_OF_PC_REGISTERS);
  localparam int ADDR_WIDTH  = $clog2(NUMBER_OF_REGISTERS);
  localparam int INSTR_WIDTH = OPERATION_TYPE_WIDTH + OPCODE_WIDTH + 3*ADDR_WIDTH
                               + PC_WIDTH + WORD_SIZE;

  typedef logic [PC_WIDTH-1:0]    pc_t;
  typedef logic [INSTR_WIDTH-1:0] instr_t;

  localparam pc_t LAST_PC = pc_t'(NUMBER_OF_PC_REGISTERS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - loader, control and fetched-instruction bundle of the fetch unit
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic   prog_we;
  pc_t    prog_addr;
  instr_t prog_data;
  logic   run;
  logic   stall;
  logic   branch_en;
  pc_t    branch_target;
  instr_t instr_out;
  logic   instr_valid;
  pc_t    pc_out;
  logic   halted;

  modport master (
    output prog_we, prog_addr, prog_data, run, stall, branch_en, branch_target,
    input  instr_out, instr_valid, pc_out, halted
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, run, stall, branch_en, branch_target,
    output instr_out, instr_valid, pc_out, halted
  );

endinterface

// File: rtl/instr_fetch_unit_instr_mem_sp.sv
// rtl/instr_fetch_unit_instr_mem_sp.sv - single-port instruction RAM, synchronous write and registered read
module instr_mem_sp #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 61,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Array has no reset so loaded programs survive a reset; only the read register clears.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - sequential instruction fetch: PC, IDLE/FETCH/HALT FSM, registered output
// Define IFU_PC_WRAP_EN to wrap PC at the last address instead of halting.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.slave  bus
);

  state_t r_state;
  state_t w_state_nxt;
  pc_t    r_pc;
  pc_t    w_pc_nxt;
  pc_t    r_pc_out;
  pc_t    w_pc_out_nxt;
  logic   r_valid;
  logic   w_valid_nxt;
  logic   w_rd_en;
  logic   w_we;
  logic   w_last_shown;
  pc_t    w_mem_addr;
  instr_t w_rdata;

  // The last instruction has been presented; the cycle after it the FSM parks in HALT.
`ifdef IFU_PC_WRAP_EN
  assign w_last_shown = 1'b0;
`else
  assign w_last_shown = r_valid && (r_pc_out == LAST_PC);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_pc_out_nxt = r_pc_out;
    w_valid_nxt  = r_valid;
    w_rd_en      = 1'b0;
    case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        if (bus.run) begin
          w_state_nxt = FETCH;
          w_pc_nxt    = '0;
        end
      end
      FETCH: begin
        if (!bus.run) begin
          w_state_nxt = IDLE;
          w_pc_nxt    = '0;
          w_valid_nxt = 1'b0;
        end else if (w_last_shown) begin
          w_state_nxt = HALT;
          w_valid_nxt = 1'b0;
        end else if (bus.branch_en) begin
          w_pc_nxt    = bus.branch_target;
          w_valid_nxt = 1'b0;
        end else if (!bus.stall) begin
          w_rd_en      = 1'b1;
          w_pc_out_nxt = r_pc;
          w_valid_nxt  = 1'b1;
          w_pc_nxt     = r_pc + 1'b1;
        end
      end
      HALT: begin
        w_valid_nxt = 1'b0;
        if (!bus.run) begin
          w_state_nxt = IDLE;
          w_pc_nxt    = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_pc_nxt    = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_pc_out <= w_pc_out_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  // Loader writes and fetch reads never overlap, so one address port is shared.
  assign w_we       = bus.prog_we && (r_state == IDLE) && !rst;
  assign w_mem_addr = (r_state == IDLE) ? bus.prog_addr : r_pc;

  instr_mem_sp #(
    .DEPTH (NUMBER_OF_PC_REGISTERS),
    .WIDTH (INSTR_WIDTH)
  ) u_imem (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_we),
    .i_re    (w_rd_en),
    .i_addr  (w_mem_addr),
    .i_wdata (bus.prog_data),
    .o_rdata (w_rdata)
  );

  assign bus.instr_out   = w_rdata;
  assign bus.instr_valid = r_valid;
  assign bus.pc_out      = r_pc_out;
`ifdef IFU_PC_WRAP_EN
  assign bus.halted      = 1'b0;
`else
  assign bus.halted      = (r_state == HALT);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [63:0] instr, input logic [63:0] pc);
    check({tag, "_valid"}, 64'(bus.instr_valid), 64'd1);
    check({tag, "_instr"}, 64'(bus.instr_out), instr);
    check({tag, "_pc"}, 64'(bus.pc_out), pc);
  endtask

  task automatic load(input pc_t a, input instr_t d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst               = 1'b1;
    bus.prog_we       = 1'b0;
    bus.prog_addr     = '0;
    bus.prog_data     = '0;
    bus.run           = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_en     = 1'b0;
    bus.branch_target = '0;
    tick();
    tick();
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_instr", 64'(bus.instr_out), 64'd0);
    check("rst_pc", 64'(bus.pc_out), 64'd0);
    check("rst_halted", 64'(bus.halted), 64'd0);
    rst = 1'b0;

    load(8'd0, 61'h10);
    load(8'd1, 61'h11);
    load(8'd2, 61'h12);
    load(8'd3, 61'h13);
    load(8'd5, 61'h55);
    load(8'd6, 61'h56);
    load(8'd7, 61'h57);
    load(8'd8, 61'hAA);
    load(8'd9, 61'hAB);
    load(8'd254, 61'hFE);
    load(8'd255, 61'hFF);
    check("idle_valid", 64'(bus.instr_valid), 64'd0);

    // Load/run: first instruction two edges after run rises
    bus.run = 1'b1;
    tick();
    check("run_lat1_valid", 64'(bus.instr_valid), 64'd0);
    tick();
    check_out("run0", 64'h10, 64'd0);
    tick();
    check_out("run1", 64'h11, 64'd1);

    // Stall three cycles on 'h11
    bus.stall = 1'b1;
    tick();
    check_out("stall_a", 64'h11, 64'd1);
    tick();
    check_out("stall_b", 64'h11, 64'd1);
    tick();
    check_out("stall_c", 64'h11, 64'd1);
    bus.stall = 1'b0;
    tick();
    check_out("run2", 64'h12, 64'd2);
    tick();
    check_out("run3", 64'h13, 64'd3);

    // Branch to 8: one bubble, then target
    bus.branch_en     = 1'b1;
    bus.branch_target = 8'd8;
    tick();
    check("br_bubble", 64'(bus.instr_valid), 64'd0);
    bus.branch_en = 1'b0;
    tick();
    check_out("br_tgt", 64'hAA, 64'd8);
    tick();
    check_out("br_next", 64'hAB, 64'd9);

    // Branch together with stall: branch wins
    bus.branch_en     = 1'b1;
    bus.branch_target = 8'd8;
    bus.stall         = 1'b1;
    tick();
    check("brst_bubble", 64'(bus.instr_valid), 64'd0);
    bus.branch_en = 1'b0;
    bus.stall     = 1'b0;
    tick();
    check_out("brst_tgt", 64'hAA, 64'd8);

    // Write protect: prog_we during FETCH must not change Imem[5]
    bus.prog_we   = 1'b1;
    bus.prog_addr = 8'd5;
    bus.prog_data = 61'hDEAD;
    tick();
    bus.prog_we = 1'b0;
    check_out("wp_fetch", 64'hAB, 64'd9);
    bus.branch_en     = 1'b1;
    bus.branch_target = 8'd5;
    tick();
    bus.branch_en = 1'b0;
    tick();
    check_out("wp_read5", 64'h55, 64'd5);
    tick();
    check_out("run6", 64'h56, 64'd6);
    tick();
    check_out("run7", 64'h57, 64'd7);

    // Reset mid-run
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", 64'(bus.instr_valid), 64'd0);
    check("mrst_pc", 64'(bus.pc_out), 64'd0);
    check("mrst_instr", 64'(bus.instr_out), 64'd0);
    check("mrst_halted", 64'(bus.halted), 64'd0);
    tick();
    check("rerun_lat_valid", 64'(bus.instr_valid), 64'd0);
    tick();
    check_out("rerun0", 64'h10, 64'd0);

    // End of program
    bus.branch_en     = 1'b1;
    bus.branch_target = 8'd254;
    tick();
    bus.branch_en = 1'b0;
    check("eop_bubble", 64'(bus.instr_valid), 64'd0);
    tick();
    check_out("eop254", 64'hFE, 64'd254);
    tick();
    check_out("eop255", 64'hFF, 64'd255);
    check("eop255_halted", 64'(bus.halted), 64'd0);
    tick();
`ifdef IFU_PC_WRAP_EN
    check_out("wrap0", 64'h10, 64'd0);
    check("wrap_halted", 64'(bus.halted), 64'd0);
`else
    check("halt_valid", 64'(bus.instr_valid), 64'd0);
    check("halt_flag", 64'(bus.halted), 64'd1);
    bus.branch_en     = 1'b1;
    bus.branch_target = 8'd3;
    bus.stall         = 1'b1;
    tick();
    bus.branch_en = 1'b0;
    bus.stall     = 1'b0;
    check("halt_br_ign_valid", 64'(bus.instr_valid), 64'd0);
    check("halt_br_ign_flag", 64'(bus.halted), 64'd1);
`endif
    bus.run = 1'b0;
    tick();
    check("stop_valid", 64'(bus.instr_valid), 64'd0);
    check("stop_halted", 64'(bus.halted), 64'd0);

    // Rerun from IDLE restarts at PC 0
    bus.run = 1'b1;
    tick();
    tick();
    check_out("restart0", 64'h10, 64'd0);
    bus.run = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
